dp_memory: RTL and testbench

- True dual-port RAM with byte enables. It is the next-generation successor to the team's single-port memory.
- Adds:
  - two independent read/write ports (A, B) on one clock;
  - parametrised read latency with per-port rvalid;
  - defined cross-port read-during-write behaviour;
  - a hardware init engine that fills the array with INIT_VALUE after reset.
- Used as shared buffer RAM between a producer and a consumer, e.g. DMA and CPU sides of a mailbox.

---
 rtl/dp_memory_pkg.sv | 12 +
 rtl/dp_memory_rd_pipe.sv | 40 ++++
 rtl/dp_memory.sv | 95 +++++++++
 tb/tb_dp_memory.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dp_memory_pkg.sv
// dp_memory_pkg: shared types, limits and parameter legality check for dp_memory
package dp_memory_pkg;
  typedef enum logic {INIT, READY} state_t;
  typedef enum logic {READ_FIRST, WRITE_FIRST} rdw_mode_t;
  localparam int MAX_READ_LATENCY = 3;
  localparam int MIN_DEPTH = 2;
  function automatic bit params_ok(input int width, input int depth, input int read_latency,
                                   input bit rdw_legal, input bit tech_legal);
    return width > 0 && width % 8 == 0 && depth >= MIN_DEPTH && read_latency >= 1 &&
           read_latency <= MAX_READ_LATENCY && rdw_legal && tech_legal;
  endfunction
endpackage

// File: rtl/dp_memory_rd_pipe.sv
// dp_memory_rd_pipe: read data/valid delay line; data only advances with valid so the output holds
module dp_memory_rd_pipe #(
  parameter int WIDTH = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);
  logic             valid_q [LATENCY];
  logic             valid_d [LATENCY];
  logic [WIDTH-1:0] data_q  [LATENCY];
  logic [WIDTH-1:0] data_d  [LATENCY];
  always_comb begin
    valid_d[0] = in_valid;
    data_d[0]  = in_valid ? in_data : data_q[0];
  end
  for (genvar i = 1; i < LATENCY; i++) begin : g_stage
    always_comb begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign out_valid = valid_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];
endmodule

// File: rtl/dp_memory.sv
// dp_memory: true dual-port byte-enable RAM with init engine and cross-port read-during-write control
module dp_memory
  import dp_memory_pkg::*;
#(
  parameter int              WIDTH         = 32,
  parameter int              DEPTH         = 1024,
  parameter int              READ_LATENCY  = 1,
  parameter string           RDW_MODE      = "READ_FIRST",
  parameter bit              INIT_ON_RESET = 1'b1,
  parameter logic [WIDTH-1:0] INIT_VALUE   = '0,
  parameter string           TECHNOLOGY    = "GENERIC",
  localparam int             AW            = $clog2(DEPTH),
  localparam int             NB            = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_cs,
  input  logic             a_we,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  input  logic [NB-1:0]    a_wstrb,
  output logic [WIDTH-1:0] a_rdata,
  output logic             a_rvalid,
  input  logic             b_cs,
  input  logic             b_we,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  input  logic [NB-1:0]    b_wstrb,
  output logic [WIDTH-1:0] b_rdata,
  output logic             b_rvalid,
  output logic             init_busy
);
  localparam bit RDW_LEGAL = RDW_MODE == "READ_FIRST" || RDW_MODE == "WRITE_FIRST";
  localparam bit TECH_LEGAL = TECHNOLOGY == "GENERIC" || TECHNOLOGY == "XILINX" ||
                              TECHNOLOGY == "ALTERA" || TECHNOLOGY == "ASIC";
  localparam rdw_mode_t RDW = (RDW_MODE == "WRITE_FIRST") ? WRITE_FIRST : READ_FIRST;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  if (!params_ok(WIDTH, DEPTH, READ_LATENCY, RDW_LEGAL, TECH_LEGAL)) begin : g_bad_params
    $error("dp_memory: illegal parameter combination");
  end
  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_q == LAST) ? READY : INIT;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT_ON_RESET ? INIT : READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  logic init_we, ready, a_in, b_in, a_wr, b_wr, a_rd, b_rd, a_fwd, b_fwd;
  logic [WIDTH-1:0] a_word, b_word;
  assign init_busy = state_q == INIT;
  assign init_we   = init_busy & rst_n;
  assign ready     = ~init_busy;
  assign a_in      = {1'b0, a_addr} < DEPTH_W;
  assign b_in      = {1'b0, b_addr} < DEPTH_W;
  assign a_wr      = ready & a_cs & a_we & a_in;
  assign b_wr      = ready & b_cs & b_we & b_in;
  assign a_rd      = ready & a_cs & ~a_we;
  assign b_rd      = ready & b_cs & ~b_we;
  // forwarding only matters for WRITE_FIRST; READ_FIRST naturally sees the pre-edge word
  assign a_fwd     = (RDW == WRITE_FIRST) & b_wr & (a_addr == b_addr);
  assign b_fwd     = (RDW == WRITE_FIRST) & a_wr & (a_addr == b_addr);
  for (genvar l = 0; l < NB; l++) begin : g_lane
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (init_we) mem[cnt_q] <= INIT_VALUE[8*l +: 8];
      else begin
        if (b_wr && b_wstrb[l]) mem[b_addr] <= b_wdata[8*l +: 8];
        if (a_wr && a_wstrb[l]) mem[a_addr] <= a_wdata[8*l +: 8];
      end
    end
    assign a_word[8*l +: 8] = !a_in ? 8'h00 : (a_fwd && b_wstrb[l]) ? b_wdata[8*l +: 8] : mem[a_addr];
    assign b_word[8*l +: 8] = !b_in ? 8'h00 : (b_fwd && a_wstrb[l]) ? a_wdata[8*l +: 8] : mem[b_addr];
  end
  dp_memory_rd_pipe #(.WIDTH(WIDTH), .LATENCY(READ_LATENCY)) u_a_pipe (
    .clk(clk), .rst_n(rst_n), .in_valid(a_rd), .in_data(a_word),
    .out_valid(a_rvalid), .out_data(a_rdata)
  );
  dp_memory_rd_pipe #(.WIDTH(WIDTH), .LATENCY(READ_LATENCY)) u_b_pipe (
    .clk(clk), .rst_n(rst_n), .in_valid(b_rd), .in_data(b_word),
    .out_valid(b_rvalid), .out_data(b_rdata)
  );
endmodule

// File: tb/tb_dp_memory.sv
// tb_dp_memory: three dp_memory variants driven in lockstep, checked against a per-variant scoreboard
module tb_dp_memory;
  localparam int ND = 3;
  localparam logic [31:0] IV = 32'hDEAD_BEEF;
  typedef struct {
    logic        cs;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } port_t;
  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;
  typedef struct {
    port_t       a;
    port_t       b;
    logic [31:0] a_exp;
    logic [31:0] b_rf;
    logic [31:0] b_wf;
  } vec_t;
  localparam port_t IDLE = '{1'b0, 1'b0, 4'd0, 32'd0, 4'd0};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic a_cs = 1'b0, a_we = 1'b0, b_cs = 1'b0, b_we = 1'b0;
  logic [3:0] a_addr = '0, b_addr = '0, a_wstrb = '0, b_wstrb = '0;
  logic [31:0] a_wdata = '0, b_wdata = '0;
  logic [31:0] rdata [ND][2];
  logic rvalid [ND][2];
  logic busy [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    dp_memory #(
      .WIDTH(32), .DEPTH(g == 2 ? 12 : 16), .READ_LATENCY(g + 1),
      .RDW_MODE(g == 1 ? "WRITE_FIRST" : "READ_FIRST"), .INIT_ON_RESET(1'b1),
      .INIT_VALUE(IV), .TECHNOLOGY("GENERIC")
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .a_cs(a_cs), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_wstrb(a_wstrb),
      .a_rdata(rdata[g][0]), .a_rvalid(rvalid[g][0]),
      .b_cs(b_cs), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_wstrb(b_wstrb),
      .b_rdata(rdata[g][1]), .b_rvalid(rvalid[g][1]),
      .init_busy(busy[g])
    );
  end

  logic [31:0] mem_m [ND][16];
  logic [31:0] last [ND][2];
  exp_t sb [ND][2][$];
  int init_left [ND];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  vec_t tbl [14];

  function automatic int dep(input int d); return d == 2 ? 12 : 16; endfunction
  function automatic int lat(input int d); return d + 1; endfunction
  function automatic bit wf(input int d); return d == 1; endfunction
  function automatic port_t rd(input int adr);
    return '{1'b1, 1'b0, 4'(adr), 32'd0, 4'd0};
  endfunction
  function automatic port_t wr(input int adr, input logic [31:0] data, input logic [3:0] strb);
    return '{1'b1, 1'b1, 4'(adr), data, strb};
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", name, d, cyc, act, exp);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < ND; d++) begin
      chk("init_busy", d, 32'(busy[d]), 32'(init_left[d] > 0));
      for (int p = 0; p < 2; p++) begin
        bit ev;
        ev = sb[d][p].size() > 0 && sb[d][p][0].due <= cyc;
        chk(p == 0 ? "a_rvalid" : "b_rvalid", d, 32'(rvalid[d][p]), 32'(ev));
        if (ev) begin
          chk(p == 0 ? "a_rdata" : "b_rdata", d, rdata[d][p], sb[d][p][0].data);
          last[d][p] = sb[d][p][0].data;
          void'(sb[d][p].pop_front());
        end else chk(p == 0 ? "a_rdata hold" : "b_rdata hold", d, rdata[d][p], last[d][p]);
      end
    end
  endtask

  task automatic step(input port_t a, input port_t b, input bit use_tbl = 1'b0,
                      input logic [31:0] a_exp = '0, input logic [31:0] b_rf = '0,
                      input logic [31:0] b_wf = '0);
    port_t pt [2];
    logic [31:0] w;
    pt[0] = a;
    pt[1] = b;
    a_cs = a.cs; a_we = a.we; a_addr = a.addr; a_wdata = a.wdata; a_wstrb = a.wstrb;
    b_cs = b.cs; b_we = b.we; b_addr = b.addr; b_wdata = b.wdata; b_wstrb = b.wstrb;
    for (int d = 0; d < ND; d++) begin
      if (init_left[d] != 0) continue;
      for (int p = 0; p < 2; p++) begin
        if (pt[p].cs && !pt[p].we) begin
          w = int'(pt[p].addr) < dep(d) ? mem_m[d][pt[p].addr] : 32'd0;
          if (wf(d) && pt[1-p].cs && pt[1-p].we && pt[1-p].addr == pt[p].addr && int'(pt[p].addr) < dep(d))
            for (int k = 0; k < 4; k++) if (pt[1-p].wstrb[k]) w[8*k +: 8] = pt[1-p].wdata[8*k +: 8];
          if (use_tbl) w = p == 0 ? a_exp : wf(d) ? b_wf : b_rf;
          sb[d][p].push_back(exp_t'{cyc + lat(d), w});
        end
      end
      for (int p = 1; p >= 0; p--)
        if (pt[p].cs && pt[p].we && int'(pt[p].addr) < dep(d))
          for (int k = 0; k < 4; k++)
            if (pt[p].wstrb[k]) mem_m[d][pt[p].addr][8*k +: 8] = pt[p].wdata[8*k +: 8];
    end
    @(posedge clk);
    cyc++;
    for (int d = 0; d < ND; d++) if (init_left[d] > 0) init_left[d]--;
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk("reset init_busy", d, 32'(busy[d]), 32'd1);
      for (int p = 0; p < 2; p++) begin
        chk("reset rvalid", d, 32'(rvalid[d][p]), 32'd0);
        chk("reset rdata", d, rdata[d][p], 32'd0);
        sb[d][p].delete();
        last[d][p] = '0;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < ND; d++) begin
      init_left[d] = dep(d);
      for (int i = 0; i < dep(d); i++) mem_m[d][i] = IV;
    end
  endtask

  initial begin
    tbl[0]  = '{wr(3, 32'h0, 4'hF), IDLE, '0, '0, '0};
    tbl[1]  = '{wr(3, 32'hAAAA_AAAA, 4'b0011), wr(3, 32'hBBBB_BBBB, 4'b0110), '0, '0, '0};
    tbl[2]  = '{IDLE, rd(3), '0, 32'h00BB_AAAA, 32'h00BB_AAAA};
    tbl[3]  = '{wr(7, 32'h1111_1111, 4'hF), IDLE, '0, '0, '0};
    tbl[4]  = '{wr(7, 32'h2222_2222, 4'b1000), rd(7), '0, 32'h1111_1111, 32'h2211_1111};
    tbl[5]  = '{IDLE, rd(7), '0, 32'h2211_1111, 32'h2211_1111};
    tbl[6]  = '{wr(1, 32'h55, 4'hF), IDLE, '0, '0, '0};
    tbl[7]  = '{rd(1), IDLE, 32'h55, '0, '0};
    tbl[8]  = '{wr(1, 32'h66, 4'hF), IDLE, '0, '0, '0};
    tbl[9]  = '{IDLE, IDLE, '0, '0, '0};
    tbl[10] = '{rd(1), IDLE, 32'h66, '0, '0};
    for (int i = 11; i < 14; i++) tbl[i] = '{IDLE, IDLE, '0, '0, '0};
    #2;
    do_reset();
    // init fill; A write during init must be dropped, B read late in init only reaches the 12-deep variant
    for (int i = 0; i < 16; i++) step(i == 3 ? wr(2, 32'h1, 4'hF) : IDLE, i == 14 ? rd(0) : IDLE);
    for (int i = 0; i < 16; i++) step(IDLE, rd(i));
    // latency, streaming, read+read and out-of-range access
    step(wr(5, 32'h1234_5678, 4'hF), IDLE);
    step(IDLE, rd(5));
    for (int i = 0; i < 8; i++) step(IDLE, rd(i));
    step(rd(5), rd(5));
    step(wr(13, 32'h77, 4'hF), rd(13));
    step(IDLE, rd(13));
    for (int i = 0; i < 4; i++) step(IDLE, IDLE);
    for (int i = 0; i < 14; i++) step(tbl[i].a, tbl[i].b, 1'b1, tbl[i].a_exp, tbl[i].b_rf, tbl[i].b_wf);
    // reset with reads in flight, then reset again at init count 8
    step(rd(5), rd(7));
    do_reset();
    for (int i = 0; i < 8; i++) step(IDLE, IDLE);
    do_reset();
    for (int i = 0; i < 16; i++) step(IDLE, IDLE);
    step(rd(7), rd(3));
    step(IDLE, rd(5));
    for (int i = 0; i < 4; i++) step(IDLE, IDLE);
    for (int d = 0; d < ND; d++)
      for (int p = 0; p < 2; p++) chk("undelivered reads", d, 32'(sb[d][p].size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
